// File: rtl/lsu_split.sv
// lsu_split: load/store unit that latches one core request, issues one or two
// aligned bus beats, and returns a single registered, extended response.
//   clock, reset_n            rising-edge clock, async active-low reset
//   req_*                     core request handshake and operands
//   resp_valid/rdata/err      one-cycle response pulse
//   io_req_valid/resp_valid   bus beat handshake
//   io_addr/size/wen/wdata/wmask/rdata  bus beat payload
module lsu_split #(
    parameter int XLEN          = 32,
    parameter int MISALIGN_MODE = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              io_req_valid,
    input  logic              io_resp_valid,
    output logic [XLEN-1:0]   io_addr,
    output logic [1:0]        io_size,
    output logic              io_wen,
    output logic [XLEN-1:0]   io_wdata,
    output logic [XLEN/8-1:0] io_wmask,
    input  logic [XLEN-1:0]   io_rdata
);
    localparam int B   = XLEN / 8;
    localparam int OFF = $clog2(B);

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;

    state_t            r_state, w_next;
    logic [XLEN-1:0]   r_addr, r_wdata, r_buf, r_rdata;
    logic [1:0]        r_size;
    logic              r_sign, r_write, r_err;

    logic              w_req_err, w_split;
    logic [OFF-1:0]    w_off;
    logic [OFF+2:0]    w_sh;
    logic [OFF+1:0]    w_n;
    logic [XLEN-1:0]   w_base, w_lo, w_hi, w_m, w_word, w_ext;
    logic [2*XLEN-1:0] w_rot, w_cat;
    logic [2*B-1:0]    w_mask2;

    // True when an access of 2^size bytes starting at lane off runs past the beat.
    function automatic logic is_split(input logic [OFF-1:0] off, input logic [1:0] size);
        return ({2'b00, off} + ((OFF+2)'(1) << size)) > (OFF+2)'(B);
    endfunction

    assign w_req_err = (req_size == 2'b11 && XLEN == 32) ||
                       (is_split(req_addr[OFF-1:0], req_size) && MISALIGN_MODE == 0);
    assign w_off     = r_addr[OFF-1:0];
    assign w_split   = is_split(w_off, r_size);
    assign w_sh      = {w_off, 3'b000};
    assign w_n       = (OFF+2)'(1) << r_size;
    assign w_base    = {r_addr[XLEN-1:OFF], {OFF{1'b0}}};

    // Store data rotation: upper half of the doubled word shifted left is a rotate.
    assign w_rot     = {r_wdata, r_wdata} << w_sh;
    assign io_wdata  = w_rot[2*XLEN-1:XLEN];

    // Mask across both beats: low half for beat 1, high half for beat 2.
    assign w_mask2   = (2*B)'((1 << w_n) - 1) << w_off;
    assign io_wmask  = !r_write ? '0 : (r_state == BEAT2) ? w_mask2[2*B-1:B] : w_mask2[B-1:0];

    assign io_size   = r_size;
    assign io_wen    = r_write;

    // In BEAT2 the buffered first beat is the low word and the live bus data the high word.
    assign w_lo      = (r_state == BEAT2) ? r_buf : io_rdata;
    assign w_hi      = (r_state == BEAT2) ? io_rdata : '0;
    assign w_cat     = {w_hi, w_lo} >> w_sh;
    assign w_m       = w_cat[XLEN-1:0];

    generate
        if (XLEN == 64) begin : g_word64
            assign w_word = {{32{r_sign & w_m[31]}}, w_m[31:0]};
        end else begin : g_word32
            assign w_word = w_m;
        end
    endgenerate

    assign w_ext = (r_size == 2'b00) ? {{(XLEN-8){r_sign & w_m[7]}}, w_m[7:0]} :
                   (r_size == 2'b01) ? {{(XLEN-16){r_sign & w_m[15]}}, w_m[15:0]} :
                   (r_size == 2'b10) ? w_word : w_m;

    assign resp_err   = resp_valid & r_err;
    assign resp_rdata = resp_valid ? r_rdata : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        req_ready    = 1'b0;
        io_req_valid = 1'b0;
        resp_valid   = 1'b0;
        io_addr      = w_base;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = w_req_err ? RESP : BEAT1;
            end
            BEAT1: begin
                io_req_valid = 1'b1;
                if (io_resp_valid) w_next = w_split ? BEAT2 : RESP;
            end
            BEAT2: begin
                io_req_valid = 1'b1;
                io_addr      = w_base + XLEN'(B);
                if (io_resp_valid) w_next = RESP;
            end
            default: begin
                resp_valid = 1'b1;
                w_next     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_sign  <= 1'b0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_buf   <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_size  <= req_size;
                r_sign  <= req_sign;
                r_write <= req_write;
                r_err   <= w_req_err;
                r_rdata <= '0;
            end
            if (r_state == BEAT1 && io_resp_valid) r_buf <= io_rdata;
            if (io_resp_valid && (r_state == BEAT2 || (r_state == BEAT1 && !w_split)))
                r_rdata <= r_write ? '0 : w_ext;
        end
    end
endmodule

// File: tb/tb_lsu_split.sv
// tb_lsu_split: table vectors, corner sequences and randomized traffic against a byte-memory model.
module tb_lsu_split;
    logic        clock = 1'b0, reset_n = 1'b0;
    logic        req_valid = 1'b0, req_valid0 = 1'b0, req_write = 1'b0, req_sign = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_ready, resp_valid, resp_err, io_req_valid, io_wen, io_resp_valid;
    logic [31:0] resp_rdata, io_addr, io_wdata;
    logic [1:0]  io_size;
    logic [3:0]  io_wmask;
    logic        bus_rv = 1'b0, stray = 1'b0;
    logic [31:0] io_rdata = '0;
    logic        req_ready0, resp_valid0, resp_err0, io_req_valid0, io_wen0;
    logic [31:0] resp_rdata0, io_addr0, io_wdata0;
    logic [1:0]  io_size0;
    logic [3:0]  io_wmask0;

    assign io_resp_valid = bus_rv | stray;

    lsu_split #(.XLEN(32), .MISALIGN_MODE(1)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_sign(req_sign), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .io_req_valid(io_req_valid), .io_resp_valid(io_resp_valid), .io_addr(io_addr),
        .io_size(io_size), .io_wen(io_wen), .io_wdata(io_wdata), .io_wmask(io_wmask),
        .io_rdata(io_rdata));

    lsu_split #(.XLEN(32), .MISALIGN_MODE(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_sign(req_sign), .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
        .io_req_valid(io_req_valid0), .io_resp_valid(1'b0), .io_addr(io_addr0),
        .io_size(io_size0), .io_wen(io_wen0), .io_wdata(io_wdata0), .io_wmask(io_wmask0),
        .io_rdata(32'h0));

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        w;
        logic [31:0] a, wd;
        logic [1:0]  sz;
        logic        sg, pre;
        logic [31:0] p0, p1, erd;
        logic        ee;
        int          el, enb;
        logic [3:0]  m0, m1;
        logic [31:0] ewd;
    } vec_t;

    int          checks = 0, errors = 0;
    logic [7:0]  bus_mem [4096];
    logic [7:0]  ref_mem [4096];
    int          busy = 0, wcnt = 0, wsum = 0, nb = 0;
    int          waits_q[$];
    bit          rand_wait = 0;
    logic [31:0] b_addr [4], b_wdata [4];
    logic [3:0]  b_mask [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] p0, input logic [31:0] p1);
        logic [31:0] w = a & ~32'h3;
        for (int j = 0; j < 4; j++) begin
            bus_mem[int'((w + 32'(j)) & 32'hFFF)]     = p0[j*8 +: 8];
            bus_mem[int'((w + 32'(j + 4)) & 32'hFFF)] = p1[j*8 +: 8];
        end
    endtask

    // Zero-or-more wait bus slave over a byte memory; called once per falling edge.
    task automatic bus_cycle();
        int idx;
        bus_rv = 1'b0;
        if (io_req_valid && reset_n) begin
            if (busy == 0) begin
                busy = 1;
                if (waits_q.size() > 0) wcnt = waits_q.pop_front();
                else wcnt = rand_wait ? int'($urandom_range(0, 2)) : 0;
                wsum += wcnt;
            end
            if (wcnt == 0) begin
                bus_rv = 1'b1;
                busy = 0;
                for (int j = 0; j < 4; j++) begin
                    idx = int'((io_addr + 32'(j)) & 32'hFFF);
                    io_rdata[j*8 +: 8] = bus_mem[idx];
                    if (io_wen && io_wmask[j]) bus_mem[idx] = io_wdata[j*8 +: 8];
                end
                if (nb < 4) begin
                    b_addr[nb] = io_addr;
                    b_wdata[nb] = io_wdata;
                    b_mask[nb] = io_wmask;
                end
                nb++;
            end else wcnt--;
        end else busy = 0;
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic sg,
                          output logic [31:0] rd, output logic er, output int lat);
        @(negedge clock);
        chk("ready_idle", {31'b0, req_ready}, 32'd1);
        req_write = w; req_addr = a; req_wdata = wd; req_size = sz; req_sign = sg;
        req_valid = 1'b1;
        nb = 0; wsum = 0;
        bus_cycle();
        @(negedge clock);
        req_valid = 1'b0;
        lat = 0; rd = 'x; er = 'x;
        for (int k = 1; k <= 40; k++) begin
            if (resp_valid) begin
                rd = resp_rdata; er = resp_err; lat = k;
                chk("ready_in_resp", {31'b0, req_ready}, 32'd0);
                break;
            end
            bus_cycle();
            @(negedge clock);
        end
        bus_rv = 1'b0;
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL resp_timeout: no resp_valid within 40 cycles for addr %h", a);
        end
    endtask

    vec_t        tbl [13];
    vec_t        v;
    logic [31:0] rd, er32, a, wd, ev;
    logic        er, w, sg, split;
    logic [1:0]  sz;
    int          lat, n, off, seen, mm;

    initial begin
        for (int i = 0; i < 4096; i++) bus_mem[i] = 8'h00;
        //          w     addr          wdata         sz  sg    pre   p0            p1            rdata         err  lat nb m0       m1       wdata
        tbl[0]  = '{1'b0, 32'h100, 32'h0,        2, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 4'b0000, 4'b0000, 32'h0};
        tbl[1]  = '{1'b0, 32'h103, 32'h0,        0, 1'b1, 1'b1, 32'h80112233, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 4'b0000, 4'b0000, 32'h0};
        tbl[2]  = '{1'b0, 32'h103, 32'h0,        0, 1'b0, 1'b1, 32'h80112233, 32'h0,        32'h00000080, 1'b0, 2, 1, 4'b0000, 4'b0000, 32'h0};
        tbl[3]  = '{1'b0, 32'h102, 32'h0,        2, 1'b0, 1'b1, 32'hAABBCCDD, 32'h11223344, 32'h3344AABB, 1'b0, 3, 2, 4'b0000, 4'b0000, 32'h0};
        tbl[4]  = '{1'b0, 32'h101, 32'h0,        1, 1'b1, 1'b1, 32'h12F67800, 32'h0,        32'hFFFFF678, 1'b0, 2, 1, 4'b0000, 4'b0000, 32'h0};
        tbl[5]  = '{1'b0, 32'h103, 32'h0,        1, 1'b0, 1'b1, 32'hAB000000, 32'h000000CD, 32'h0000CDAB, 1'b0, 3, 2, 4'b0000, 4'b0000, 32'h0};
        tbl[6]  = '{1'b0, 32'h100, 32'h0,        3, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00000000, 1'b1, 1, 0, 4'b0000, 4'b0000, 32'h0};
        tbl[7]  = '{1'b1, 32'h1FF, 32'h11223344, 2, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00000000, 1'b0, 3, 2, 4'b1000, 4'b0111, 32'h44112233};
        tbl[8]  = '{1'b0, 32'h1FC, 32'h0,        2, 1'b0, 1'b0, 32'h0,        32'h0,        32'h44000000, 1'b0, 2, 1, 4'b0000, 4'b0000, 32'h0};
        tbl[9]  = '{1'b0, 32'h200, 32'h0,        2, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00112233, 1'b0, 2, 1, 4'b0000, 4'b0000, 32'h0};
        tbl[10] = '{1'b1, 32'h102, 32'h000000AB, 0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00000000, 1'b0, 2, 1, 4'b0100, 4'b0000, 32'h00AB0000};
        tbl[11] = '{1'b0, 32'h102, 32'h0,        0, 1'b1, 1'b0, 32'h0,        32'h0,        32'hFFFFFFAB, 1'b0, 2, 1, 4'b0000, 4'b0000, 32'h0};
        tbl[12] = '{1'b1, 32'h106, 32'h00001234, 1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00000000, 1'b0, 2, 1, 4'b1100, 4'b0000, 32'h12340000};

        // Reset state
        #1;
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_io_req_valid", {31'b0, io_req_valid}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed vector table, zero-wait bus
        for (int i = 0; i < 13; i++) begin
            v = tbl[i];
            if (v.pre) preload(v.a, v.p0, v.p1);
            do_req(v.w, v.a, v.wd, v.sz, v.sg, rd, er, lat);
            chk($sformatf("t%0d_rdata", i), rd, v.erd);
            chk($sformatf("t%0d_err", i), {31'b0, er}, {31'b0, v.ee});
            chk($sformatf("t%0d_lat", i), 32'(lat), 32'(v.el));
            chk($sformatf("t%0d_beats", i), 32'(nb), 32'(v.enb));
            if (v.enb > 0) begin
                chk($sformatf("t%0d_addr0", i), b_addr[0], v.a & ~32'h3);
                chk($sformatf("t%0d_mask0", i), {28'b0, b_mask[0]}, {28'b0, v.m0});
                if (v.w) chk($sformatf("t%0d_wdata0", i), b_wdata[0], v.ewd);
            end
            if (v.enb == 2) begin
                chk($sformatf("t%0d_addr1", i), b_addr[1], (v.a & ~32'h3) + 32'd4);
                chk($sformatf("t%0d_mask1", i), {28'b0, b_mask[1]}, {28'b0, v.m1});
                if (v.w) chk($sformatf("t%0d_wdata1", i), b_wdata[1], v.ewd);
            end
        end

        // Reset in the middle of a waiting second beat, across the address wrap
        preload(32'hFFFFFFFC, 32'hBBAA0000, 32'h0000DDCC);
        waits_q = {0, 3};
        @(negedge clock);
        req_write = 1'b0; req_addr = 32'hFFFFFFFE; req_size = 2'b10; req_sign = 1'b0;
        req_valid = 1'b1; nb = 0;
        bus_cycle();
        @(negedge clock);
        req_valid = 1'b0;
        chk("mid_b1_valid", {31'b0, io_req_valid}, 32'd1);
        chk("mid_b1_addr", io_addr, 32'hFFFFFFFC);
        bus_cycle();
        @(negedge clock);
        chk("mid_b2_valid", {31'b0, io_req_valid}, 32'd1);
        chk("mid_b2_addr", io_addr, 32'h00000000);
        bus_cycle();
        #2 reset_n = 1'b0;
        #1 chk("mid_async_drop", {31'b0, io_req_valid}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        bus_cycle();
        chk("mid_ready_after", {31'b0, req_ready}, 32'd1);
        stray = 1'b1;
        @(negedge clock);
        stray = 1'b0;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            seen |= int'(resp_valid);
            @(negedge clock);
        end
        chk("mid_stray_no_resp", 32'(seen), 32'd0);
        waits_q.delete();
        do_req(1'b0, 32'hFFFFFFFE, 32'h0, 2'b10, 1'b0, rd, er, lat);
        chk("wrap_rdata", rd, 32'hDDCCBBAA);
        chk("wrap_lat", 32'(lat), 32'd3);
        chk("wrap_b2_addr", b_addr[1], 32'h00000000);

        // Fault mode: misaligned half and illegal double size
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk($sformatf("m0_%0d_ready", i), {31'b0, req_ready0}, 32'd1);
            req_write = 1'b0; req_wdata = '0;
            req_addr = (i == 0) ? 32'h0FF : 32'h100;
            req_size = (i == 0) ? 2'b01 : 2'b11;
            req_valid0 = 1'b1;
            @(negedge clock);
            req_valid0 = 1'b0;
            chk($sformatf("m0_%0d_resp", i), {31'b0, resp_valid0}, 32'd1);
            chk($sformatf("m0_%0d_err", i), {31'b0, resp_err0}, 32'd1);
            chk($sformatf("m0_%0d_rdata", i), resp_rdata0, 32'd0);
            seen = int'(io_req_valid0);
            @(negedge clock);
            seen |= int'(io_req_valid0);
            chk($sformatf("m0_%0d_no_bus", i), 32'(seen), 32'd0);
            chk($sformatf("m0_%0d_pulse", i), {31'b0, resp_valid0}, 32'd0);
        end

        // Randomized traffic against a byte-addressed memory model
        for (int i = 0; i < 4096; i++) ref_mem[i] = bus_mem[i];
        rand_wait = 1;
        for (int t = 0; t < 300; t++) begin
            a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            w = 1'($urandom);
            wd = $urandom;
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom);
            n = 1 << sz;
            off = int'(a & 32'h3);
            split = (off + n) > 4;
            do_req(w, a, wd, sz, sg, rd, er, lat);
            if (sz == 2'b11) begin
                chk("rnd_err", {31'b0, er}, 32'd1);
                chk("rnd_err_rdata", rd, 32'd0);
                chk("rnd_err_lat", 32'(lat), 32'd1);
                chk("rnd_err_beats", 32'(nb), 32'd0);
            end else begin
                ev = '0;
                for (int j = 0; j < n; j++) begin
                    if (w) ref_mem[int'((a + 32'(j)) & 32'hFFF)] = wd[j*8 +: 8];
                    else ev |= 32'(ref_mem[int'((a + 32'(j)) & 32'hFFF)]) << (8 * j);
                end
                if (!w && sg && n < 4 && ev[8*n-1]) ev |= 32'hFFFFFFFF << (8 * n);
                chk("rnd_rdata", rd, w ? 32'd0 : ev);
                chk("rnd_err", {31'b0, er}, 32'd0);
                chk("rnd_lat", 32'(lat), 32'(1 + (split ? 2 : 1) + wsum));
                chk("rnd_beats", 32'(nb), split ? 32'd2 : 32'd1);
                chk("rnd_addr0", b_addr[0], a & ~32'h3);
                if (split) chk("rnd_addr1", b_addr[1], (a & ~32'h3) + 32'd4);
            end
        end
        mm = 0;
        for (int i = 0; i < 4096; i++) if (bus_mem[i] !== ref_mem[i]) mm++;
        chk("rnd_mem_image", 32'(mm), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
